// File: rtl/connectnet_pkg.sv
// Shared definitions for the connection-net arbiter: FSM encoding and a
// constant-evaluable ceiling log2 used to size index and counter fields.
package connectnet_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/connectnet_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping modulo NUM_REQ. any is low when nobody requests.
module connectnet_rr_pick
    import connectnet_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int          idx;
        logic [IW-1:0] idx_l;
        idx     = 0;
        idx_l   = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_l = IW'(idx);
            if (req[idx_l]) begin
                gnt_idx = idx_l;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/connectnet_arbiter.sv
// Packet-granular round-robin arbiter with a burst cap, driving a shared
// point-to-point net (data + last) from a single output register.
module connectnet_arbiter
    import connectnet_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int GW = clog2(NUM_REQ),
    localparam int CW = clog2(MAX_BURST + 1)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic [NUM_REQ-1:0]      req_ready_c;
    logic                    accept;
    logic [CW-1:0]           beat_inc;
    logic [GW-1:0]           pick_idx;
    logic                    pick_any;
    logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];

    // Split the flat requester data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    connectnet_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state: arbitration in IDLE, beat forwarding and release in GRANTED.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        req_ready_c = '0;
        accept      = 1'b0;
        beat_inc    = beat_cnt_q + CW'(1);

        // Drained beat leaves the register empty unless a new one is loaded.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANTED;
                end
            end
            GRANTED: begin
                req_ready_c[grant_q] = !out_valid_q || out_ready;
                accept = req_ready_c[grant_q] && req_valid[grant_q];
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = req_word[grant_q];
                    out_last_d  = req_last[grant_q];
                    beat_cnt_d  = beat_inc;
                    // End of packet or burst cap hands the net to the next index.
                    if (req_last[grant_q] || (beat_inc == CW'(MAX_BURST))) begin
                        rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output register; reset discards any in-flight beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign req_ready = req_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == GRANTED);

endmodule

// File: tb/tb_connectnet_arbiter.sv
// Directed bench for connectnet_arbiter (NUM_REQ=4, MAX_BURST=4): reset,
// fairness, burst cap, backpressure, valid gaps and reset mid-packet.
module tb_connectnet_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic [1:0]        grant_id;
    logic              busy;

    logic [NR-1:0]     src_has = '0;
    logic [NR-1:0]     hold    = '0;
    logic [NR-1:0]     fire_s  = '0;
    logic [32:0]       src_q [NR][$];
    logic [32:0]       mon_q [$];
    int                mon_cyc [$];
    logic [32:0]       exp_q [$];
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    assign req_valid = src_has & ~hold;

    connectnet_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Cycle counter for beat spacing.
    always @(posedge CLK) cyc <= cyc + 1;

    // Requester sources: retire accepted heads, present the next beat.
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                src_has[i]            = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0][31:0];
                req_last[i]           = src_q[i][0][32];
            end else begin
                src_has[i]            = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    end

    // Mid-cycle sampling of requester and net handshakes.
    always @(negedge CLK) begin
        fire_s <= RST ? '0 : (req_valid & req_ready);
        if (out_valid && out_ready) begin
            mon_q.push_back({out_last, out_data});
            mon_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_q.delete();
        mon_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_drain(input string tag, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                src_q[3].size() == 0 && !busy && !out_valid && src_has == '0) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        check({tag, "_drain"}, done, 1);
    endtask

    task automatic wait_out_valid(input string tag, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        check({tag, "_outvalid"}, seen, 1);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_count"}, mon_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < mon_q.size()) check($sformatf("%s_beat%0d", tag, k), mon_q[k], exp_q[k]);
        end
    endtask

    initial begin
        RST       = 1'b1;
        out_ready = 1'b1;
        hold      = '0;

        // Reset with every requester holding three 1-beat packets.
        for (int i = 0; i < NR; i++)
            for (int n = 1; n <= 3; n++)
                src_q[i].push_back({1'b1, 32'(i * 256 + n)});
        step(3);
        $display("reset: req_valid=%b", req_valid);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);

        // Fairness: grant order 0,1,2,3 repeating, one beat per two cycles.
        clear_mon();
        RST = 1'b0;
        wait_drain("fair", 200);
        for (int k = 0; k < 12; k++) exp_q.push_back({1'b1, 32'((k % 4) * 256 + k / 4 + 1)});
        cmp_stream("fair");
        for (int k = 1; k < 12; k++)
            if (k < mon_cyc.size()) check($sformatf("fair_gap%0d", k), mon_cyc[k] - mon_cyc[k-1], 2);
        $display("fairness: %0d beats", mon_q.size());

        // Burst cap: 10-beat packet from 2 interleaved with 1 beat from 3.
        clear_mon();
        for (int n = 1; n <= 10; n++) src_q[2].push_back({(n == 10), 32'h2000_0000 + 32'(n)});
        src_q[3].push_back({1'b1, 32'h3000_0001});
        step(1);
        wait_drain("burst", 200);
        for (int n = 1; n <= 4; n++) exp_q.push_back({1'b0, 32'h2000_0000 + 32'(n)});
        exp_q.push_back({1'b1, 32'h3000_0001});
        for (int n = 5; n <= 10; n++) exp_q.push_back({(n == 10), 32'h2000_0000 + 32'(n)});
        cmp_stream("burst");
        $display("burst: %0d beats", mon_q.size());

        // Backpressure: stall the net for 5 cycles with A1 on it.
        clear_mon();
        src_q[0].push_back({1'b0, 32'h0000_00A1});
        src_q[0].push_back({1'b0, 32'h0000_00A2});
        src_q[0].push_back({1'b1, 32'h0000_00A3});
        step(1);
        wait_out_valid("bp", 20);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_data%0d", k), out_data, 32'h0000_00A1);
            check($sformatf("bp_valid%0d", k), out_valid, 1);
            check($sformatf("bp_ready%0d", k), req_ready, 0);
            step(1);
        end
        out_ready = 1'b1;
        wait_drain("bp", 50);
        exp_q.push_back({1'b0, 32'h0000_00A1});
        exp_q.push_back({1'b0, 32'h0000_00A2});
        exp_q.push_back({1'b1, 32'h0000_00A3});
        cmp_stream("bp");
        $display("backpressure: %0d beats", mon_q.size());

        // Valid gap: requester 1 pauses mid-packet while requester 0 waits.
        clear_mon();
        src_q[1].push_back({1'b0, 32'h0000_00B1});
        src_q[1].push_back({1'b0, 32'h0000_00B2});
        src_q[1].push_back({1'b1, 32'h0000_00B3});
        src_q[0].push_back({1'b1, 32'h0000_00C1});
        step(1);
        wait_out_valid("gap", 20);
        hold[1] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("gap_grant%0d", k), grant_id, 1);
            check($sformatf("gap_busy%0d", k), busy, 1);
            check($sformatf("gap_ready%0d", k), req_ready, 4'b0010);
            step(1);
        end
        hold[1] = 1'b0;
        wait_drain("gap", 50);
        exp_q.push_back({1'b0, 32'h0000_00B1});
        exp_q.push_back({1'b0, 32'h0000_00B2});
        exp_q.push_back({1'b1, 32'h0000_00B3});
        exp_q.push_back({1'b1, 32'h0000_00C1});
        cmp_stream("gap");
        check("gap_idle_grant", grant_id, 0);
        $display("gap: %0d beats", mon_q.size());

        // Reset while requester 2 owns the net with a beat in the register.
        clear_mon();
        src_q[2].push_back({1'b0, 32'h0000_00D1});
        src_q[2].push_back({1'b0, 32'h0000_00D2});
        src_q[2].push_back({1'b1, 32'h0000_00D3});
        step(1);
        wait_out_valid("mrst", 20);
        check("mrst_pre_grant", grant_id, 2);
        check("mrst_pre_busy", busy, 1);
        src_q[0].push_back({1'b1, 32'h0000_00F1});
        RST = 1'b1;
        step(1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_grant", grant_id, 0);
        check("mrst_ready", req_ready, 0);
        RST = 1'b0;
        step(1);
        check("mrst_regrant", grant_id, 0);
        check("mrst_regrant_busy", busy, 1);
        wait_drain("mrst", 50);
        exp_q.push_back({1'b0, 32'h0000_00D1});
        exp_q.push_back({1'b1, 32'h0000_00F1});
        exp_q.push_back({1'b0, 32'h0000_00D2});
        exp_q.push_back({1'b1, 32'h0000_00D3});
        cmp_stream("mrst");
        $display("reset mid-op: %0d beats", mon_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/connectnet_arbiter.md
# connectnet_arbiter

Shares one point-to-point connection net (a single data word plus last flag per cycle) among `NUM_REQ` requesters. Arbitration is round-robin at packet granularity with a burst cap. The block sits in front of the shared net, between the requester-side pipes and the single downstream consumer. It registers the forwarded beat, so the shared net is always driven from a flop.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; range 2–16.
- `DATA_WIDTH`, 32: width of the shared net data word.
- `MAX_BURST`, 16: maximum beats forwarded per grant before forced release; range 1–256.

Ports:
- `CLK`  in  1: single clock. All state changes on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i drives bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ: per-requester end-of-packet flag.
- `req_ready`  out  NUM_REQ: one-hot or zero; beat accepted when `req_valid[i] && req_ready[i]`.
- `out_valid`  out  1: shared net beat valid (registered).
- `out_data`  out  DATA_WIDTH: shared net data (registered).
- `out_last`  out  1: shared net last flag (registered).
- `out_ready`  in  1: downstream accepts when `out_valid && out_ready`.
- `grant_id`  out  clog2(NUM_REQ): index of the current owner; holds the last owner while idle.
- `busy`  out  1: high in GRANTED.

## Operation
- FSM states are IDLE and GRANTED.
- IDLE:
  - If any `req_valid` is set, pick the first set index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Load `grant_id`, clear `beat_cnt`, go to GRANTED.
  - No `req_ready` is asserted in IDLE.
- GRANTED:
  - `req_ready[grant_id] = !out_valid || out_ready`. All other `req_ready` bits are 0.
  - On acceptance, load the output register with data/last and increment `beat_cnt`.
- Release happens on the accepting edge when the accepted beat has `req_last=1`, or when `beat_cnt+1 == MAX_BURST`.
  - On release: `rr_ptr <= (grant_id+1) mod NUM_REQ`, go to IDLE.
  - A forced release at MAX_BURST forwards `out_last` exactly as the requester supplied it. The packet resumes on that requester's next grant.
- Output register:
  - Cleared (`out_valid` to 0) when `out_valid && out_ready` and no new beat is loaded.
  - Simultaneous drain and load is a full-throughput pass.
- A requester dropping `req_valid` mid-packet does not release the grant. The arbiter waits; there is no timeout.
- `beat_cnt` is clog2(MAX_BURST+1) bits wide and never wraps; release fires before overflow.
- Reset in any state:
  - Returns to IDLE with `rr_ptr=0` and `beat_cnt=0`.
  - Clears the output register. Any in-flight beat is discarded.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`
  - `req_ready=0`, `grant_id=0`, `busy=0`
- Arbitration latency: request seen in IDLE at cycle t → `busy`=1 and `req_ready[g]` possible at t+1.
- Data latency: beat accepted at cycle k → on the shared net at k+1.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Re-arbitration costs one IDLE bubble cycle per grant. A single-beat packet therefore occupies 2 arbiter cycles.
- `out_valid`, `out_data` and `out_last` are stable while `out_valid && !out_ready`.

## Structure
- Package `connectnet_pkg` holds:
  - the FSM state enum `{IDLE, GRANTED}`;
  - the function `clog2`;
  - no data typedefs, since widths are parameterised.
- Sub-module `connectnet_rr_pick` is a combinational round-robin picker: inputs `req[NUM_REQ]` and `ptr`; outputs `gnt_idx` and `any`.
- The top level instantiates one picker, the FSM, `beat_cnt` and the output register.

## Test plan
- Reset: assert RST for 3 cycles while all `req_valid=1`. Required: all outputs are 0 on the cycle after reset.
- Fairness: NUM_REQ=4, all requesters continuously send 1-beat packets, `out_ready=1`. Required: grant order 0,1,2,3,0,… and one beat every 2 cycles.
- Burst cap: MAX_BURST=4, requester 2 sends a 10-beat packet and requester 3 sends 1 beat. Required: the net shows 4 beats from 2, then 1 beat from 3, then 4 from 2, then 2 from 2; `out_last` is set only on the 10th beat from 2.
- Backpressure: hold `out_ready=0` for 5 cycles mid-packet. Required: `out_data` is unchanged, `req_ready[g]=0`, and no beat is lost or duplicated; a 3-beat packet arrives intact as 0xA1, 0xA2, 0xA3.
- Gap in requester valid: requester 1 drops `req_valid` for 3 cycles mid-packet while requester 0 requests. Required: `grant_id` stays 1 until requester 1's last beat is accepted.
- Reset mid-operation: assert RST while GRANTED with `out_valid=1`. Required: `out_valid=0` next cycle, then arbitration restarts from index 0.
